// File: rtl/spart_rx.sv
// spart_rx: receive half of the SPART. It assembles oversampled 8N1 frames, LSB first,
// into a byte holding register and reports data-ready, framing error and overrun.
module spart_rx #(
    parameter int DW  = 8,
    parameter int OVS = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd,
    input  logic          brg_tick,
    input  logic          rd,
    output logic [DW-1:0] rx_data,
    output logic          rda,
    output logic          framing_err,
    output logic          overrun
);
    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DW + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state_q;
    logic [SW-1:0] samp_cnt_q;
    logic [BW-1:0] bit_cnt_q;
    logic [DW-1:0] shift_q;
    logic          rxd_m_q, rxd_s_q;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic          rda_q, rda_d;
    logic          framing_err_q, framing_err_d;
    logic          overrun_q, overrun_d;
    logic          mid_half, mid_bit, load, stop_bad;

    assign mid_half = samp_cnt_q == SW'(OVS / 2 - 1);
    assign mid_bit  = samp_cnt_q == SW'(OVS - 1);
    assign load     = brg_tick && state_q == STOP && mid_bit && rxd_s_q;
    assign stop_bad = brg_tick && state_q == STOP && mid_bit && !rxd_s_q;

    // Two-flop synchronizer for the asynchronous line; it resets to the idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            rxd_m_q <= rxd;
            rxd_s_q <= rxd_m_q;
        end
    end

    // Frame FSM. It moves only on baud ticks and samples each bit at its centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else if (brg_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s_q) begin
                        state_q    <= START;
                        samp_cnt_q <= '0;
                    end
                end
                START: begin
                    if (mid_half) begin
                        state_q    <= rxd_s_q ? IDLE : DATA;
                        samp_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end else begin
                        samp_cnt_q <= samp_cnt_q + SW'(1);
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        shift_q    <= {rxd_s_q, shift_q[DW-1:1]};
                        samp_cnt_q <= '0;
                        bit_cnt_q  <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BW'(DW - 1)) state_q <= STOP;
                    end else begin
                        samp_cnt_q <= samp_cnt_q + SW'(1);
                    end
                end
                STOP: begin
                    if (mid_bit) begin
                        state_q    <= rxd_s_q ? IDLE : BRK;
                        samp_cnt_q <= '0;
                    end else begin
                        samp_cnt_q <= samp_cnt_q + SW'(1);
                    end
                end
                BRK: begin
                    if (rxd_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus-side status. A load beats a same-cycle read, and a read clears overrun.
    always_comb begin
        rx_data_d     = load ? shift_q : rx_data_q;
        rda_d         = load | (rda_q & ~rd);
        overrun_d     = (load & rda_q & ~rd) | (overrun_q & ~rd);
        framing_err_d = stop_bad | (framing_err_q & ~load);
    end

    // Holding register and sticky flags. These are serviced on every clock, with or without a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q     <= '0;
            rda_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rx_data_q     <= rx_data_d;
            rda_q         <= rda_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
endmodule
